// File: rtl/leaf_uart_pkg.sv
// Shared constants and FSM encoding for the leaf chip UART receive path.
package leaf_uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_rx_state_e;

  // Plain constants keep the state register a bare vector for legacy tooling.
  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_START = S_START;
  localparam logic [2:0] ST_DATA  = S_DATA;
  localparam logic [2:0] ST_STOP  = S_STOP;
  localparam logic [2:0] ST_BREAK = S_BREAK;

endpackage

// File: rtl/leaf_uart_rx_fifo.sv
// Circular receive buffer for leaf_uart_rx; only built when LEAF_UART_RX_FIFO_EN is defined.
module leaf_uart_rx_fifo
  import leaf_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/leaf_uart_rx.sv
// 8N1 UART receiver with valid/ready output; define LEAF_UART_RX_FIFO_EN for a
// FIFO_DEPTH-entry buffer, otherwise a single holding register is used.
module leaf_uart_rx
  import leaf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic                      rx_meta;
  logic                      rxs;
  logic [2:0]                state;
  logic [CW-1:0]             baud_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      stop_sample;
  logic                      push_req;
  logic                      pop;
  logic                      buf_full;
  logic                      buf_valid;
  logic [UART_DATA_BITS-1:0] buf_data;

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state    <= ST_START;
            baud_cnt <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (!rxs) begin
            state    <= ST_DATA;
            baud_cnt <= BIT_LOAD;
            bit_cnt  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            shift    <= {rxs, shift[UART_DATA_BITS-1:1]};
            baud_cnt <= BIT_LOAD;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            // Returning to IDLE at mid stop bit leaves room for a back-to-back start.
            state <= rxs ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stop_sample = (state == ST_STOP) && (baud_cnt == '0);
  assign push_req    = stop_sample & rxs;
  assign pop         = buf_valid & rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample & ~rxs;
      overrun   <= push_req & buf_full & ~pop;
    end
  end

`ifdef LEAF_UART_RX_FIFO_EN
  logic fifo_empty;

  leaf_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (shift),
    .dout  (buf_data),
    .full  (buf_full),
    .empty (fifo_empty)
  );

  assign buf_valid = ~fifo_empty;
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;
  logic                      unused_fifo_depth;

  assign unused_fifo_depth = ^FIFO_DEPTH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push_req && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= shift;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_valid = hold_valid;
  assign buf_data  = hold_data;
`endif

  assign rx_valid = buf_valid;
  assign rx_data  = buf_valid ? buf_data : '0;

endmodule
